// File: rtl/uart_tx_only.sv
// -----------------------------------------------------------------------------
// uart_tx_only
//
// Byte-stream UART transmitter: a FIFO_DEPTH-entry byte FIFO feeding an 8N1
// serializer that drives the board TX line. It sits directly behind the line
// feeder. The feeder samples o_tx_ready once and then pushes a whole line
// (READY_FREE bytes) back-to-back without checking ready again, so ready is
// only high while that many entries are free.
//
// Handshake: i_tx_valid is a plain enqueue strobe with no ready qualification.
// Every cycle it is high, one byte is offered. The byte is stored if the FIFO
// has room, or if a pop frees an entry on the same edge. Otherwise the byte is
// dropped and o_overflow latches high until reset. o_tx_ready is advisory
// only: it reports that at least READY_FREE entries are free.
//
// Ports:
//   i_clk_20mhz   in   1  system clock (20 MHz)
//   i_rstn_20mhz  in   1  synchronous active-low reset
//   i_tx_data     in   8  byte to enqueue
//   i_tx_valid    in   1  enqueue strobe, one byte per high cycle
//   o_tx_ready    out  1  free entries >= READY_FREE
//   o_uart_tx     out  1  registered serial line, idle high
//   o_busy        out  1  FIFO non-empty or a frame in flight
//   o_overflow    out  1  sticky: a byte was dropped because the FIFO was full
//   dbg_state     out  2  serializer state (0 IDLE, 1 START, 2 DATA, 3 STOP)
// -----------------------------------------------------------------------------
module uart_tx_only #(
  parameter int CLKS_PER_BIT = 174,
  parameter int FIFO_DEPTH   = 64,
  parameter int READY_FREE   = 34
) (
  input  logic       i_clk_20mhz,
  input  logic       i_rstn_20mhz,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic       o_overflow,
  output logic [1:0] dbg_state
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  localparam int AW = $clog2(FIFO_DEPTH);
  // The count must represent FIFO_DEPTH itself, so it is one bit wider than a pointer.
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FREE_MIN  = CW'(READY_FREE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic          pop;
  logic          push;
  logic          drop;
  logic          baud_done;
  logic [CW-1:0] free_cnt;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  // A pop only happens when count is nonzero. Because of that, a push while
  // full is legal on a popping edge: the freed slot takes the new byte.
  assign push = i_tx_valid && ((count_q != DEPTH_C) || pop);
  assign drop = i_tx_valid && (count_q == DEPTH_C) && !pop;

  assign free_cnt  = DEPTH_C - count_q;
  assign baud_done = (baud_q == BAUD_LAST);

  // The memory needs no reset. Pointers and count define what is valid.
  always_ff @(posedge i_clk_20mhz) begin
    if (push) begin
      mem[wr_ptr_q] <= i_tx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer next-state / outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        // The start bit goes out on the edge right after the byte lands.
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // LSB first. The register shifts right, so the next bit sits at [1].
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Go straight into the next start bit so frames are contiguous.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;

      // The pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_uart_tx  = tx_q;
  assign o_tx_ready = (free_cnt >= FREE_MIN);
  assign o_busy     = (count_q != '0) || (state_q != IDLE);
  assign o_overflow = overflow_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_only.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_only
//
// Drives random and fixed byte streams into uart_tx_only. A separate line
// monitor decodes 8N1 frames from o_uart_tx and compares each decoded byte
// with the front of an expected queue. The stimulus fills that queue in write
// order, skipping bytes that must be dropped. The bit time is shortened so the
// long bursts fit in a short run.
// -----------------------------------------------------------------------------
module tb_uart_tx_only;

  localparam int CLKS  = 16;
  localparam int FRAME = 10 * CLKS;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       i_clk_20mhz = 1'b0;
  logic       i_rstn_20mhz = 1'b0;
  logic [7:0] i_tx_data = 8'h00;
  logic       i_tx_valid = 1'b0;
  logic       o_tx_ready;
  logic       o_uart_tx;
  logic       o_busy;
  logic       o_overflow;
  logic [1:0] dbg_state;

  always #25 i_clk_20mhz = ~i_clk_20mhz;

  int unsigned cyc = 0;
  always @(posedge i_clk_20mhz) cyc <= cyc + 1;

  uart_tx_only #(
    .CLKS_PER_BIT(CLKS),
    .FIFO_DEPTH  (64),
    .READY_FREE  (34)
  ) dut (
    .i_clk_20mhz (i_clk_20mhz),
    .i_rstn_20mhz(i_rstn_20mhz),
    .i_tx_data   (i_tx_data),
    .i_tx_valid  (i_tx_valid),
    .o_tx_ready  (o_tx_ready),
    .o_uart_tx   (o_uart_tx),
    .o_busy      (o_busy),
    .o_overflow  (o_overflow),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  stim_q[$];
  int unsigned start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line monitor: decodes 8N1 frames, sampling each bit at its midpoint
  // ---------------------------------------------------------------------------
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;
  logic       prev_line = 1'b1;

  always @(negedge i_clk_20mhz) begin
    if (!i_rstn_20mhz) begin
      mon_active = 1'b0;
      prev_line  = 1'b1;
    end else begin
      if (!mon_active) begin
        if (prev_line && !o_uart_tx) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          start_q.push_back(cyc);
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == CLKS / 2) begin
          check("start_bit", o_uart_tx, 1'b0);
        end else if (mon_cnt == CLKS / 2 + 9 * CLKS) begin
          check("stop_bit", o_uart_tx, 1'b1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=0x%02h required=no_frame", mon_byte);
          end else begin
            check("rx_byte", mon_byte, exp_q.pop_front());
          end
          mon_active = 1'b0;
        end else if (mon_cnt > CLKS / 2 && ((mon_cnt - CLKS / 2) % CLKS) == 0) begin
          mon_byte[(mon_cnt - CLKS / 2) / CLKS - 1] = o_uart_tx;
        end
      end
      prev_line = o_uart_tx;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(posedge i_clk_20mhz); #1;
    i_rstn_20mhz = 1'b0;
    repeat (3) begin
      @(posedge i_clk_20mhz); #1;
    end
    i_rstn_20mhz = 1'b1;
    start_q.delete();
  endtask

  // Pushes stim_q back-to-back. Only the first n_expect bytes are expected
  // on the line. e0 is the cycle stamp of the first write edge.
  task automatic push_all(input int n_expect, output int unsigned e0);
    e0 = cyc;
    for (int i = 0; i < stim_q.size(); i++) begin
      i_tx_valid = 1'b1;
      i_tx_data  = stim_q[i];
      if (i < n_expect) exp_q.push_back(stim_q[i]);
      @(posedge i_clk_20mhz); #1;
      if (i == 0) e0 = cyc;
    end
    i_tx_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_idle(input int budget, output int unsigned t);
    int n;
    n = 0;
    @(negedge i_clk_20mhz);
    while (o_busy && n < budget) begin
      @(negedge i_clk_20mhz);
      n++;
    end
    t = cyc;
    if (o_busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle after %0d cycles", budget);
    end
    @(posedge i_clk_20mhz); #1;
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) begin
      @(posedge i_clk_20mhz); #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  initial begin
    int unsigned e0, e1, t;

    // Reset state
    do_reset();
    @(negedge i_clk_20mhz);
    check("rst_uart_tx", o_uart_tx, 1'b1);
    check("rst_ready", o_tx_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_overflow", o_overflow, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    @(posedge i_clk_20mhz); #1;

    // Single byte: start bit one edge after the write, idle one frame later
    start_q.delete();
    stim_q.delete();
    stim_q.push_back(8'h55);
    push_all(1, e0);
    wait_idle(FRAME + 50, t);
    check("single_frames", start_q.size(), 1);
    if (start_q.size() > 0) check("single_latency", start_q[0], e0 + 1);
    check("single_busy_fall", t, e0 + 1 + FRAME);
    check("single_line_idle", o_uart_tx, 1'b1);

    // Feeder line: 34 contiguous frames
    start_q.delete();
    stim_q.delete();
    for (int i = 0; i < 32; i++) stim_q.push_back(8'h20);
    stim_q.push_back(8'h0D);
    stim_q.push_back(8'h0A);
    push_all(34, e0);
    wait_idle(34 * FRAME + 50, t);
    check("feeder_frames", start_q.size(), 34);
    check("feeder_total", t, e0 + 1 + 34 * FRAME);
    for (int i = 1; i < start_q.size(); i++)
      check("feeder_spacing", start_q[i] - start_q[i-1], FRAME);
    check("feeder_overflow", o_overflow, 1'b0);

    // Ready threshold: 31 writes leave 30 queued, one more leaves 31
    fill_random(31);
    push_all(31, e0);
    check("ready_at_30", o_tx_ready, 1'b1);
    fill_random(1);
    push_all(1, e1);
    check("ready_at_31", o_tx_ready, 1'b0);
    wait_until(e0 + FRAME);
    check("ready_before_pop", o_tx_ready, 1'b0);
    @(posedge i_clk_20mhz); #1;
    check("ready_after_pop", o_tx_ready, 1'b1);
    wait_idle(33 * FRAME, t);

    // Overflow: 65 accepted (64 queued + 1 in flight), 5 dropped
    start_q.delete();
    fill_random(65);
    push_all(65, e0);
    check("ovf_before_full", o_overflow, 1'b0);
    check("ovf_ready_full", o_tx_ready, 1'b0);
    fill_random(5);
    push_all(0, e1);
    check("ovf_set", o_overflow, 1'b1);
    wait_idle(66 * FRAME, t);
    check("ovf_frames", start_q.size(), 65);
    check("ovf_sticky", o_overflow, 1'b1);
    check("ovf_ready_idle", o_tx_ready, 1'b1);

    // Reset clears overflow. Then pointer wrap across two batches of 40.
    do_reset();
    check("ovf_cleared", o_overflow, 1'b0);
    fill_random(40);
    push_all(40, e0);
    wait_idle(41 * FRAME, t);
    fill_random(40);
    push_all(40, e0);
    wait_idle(41 * FRAME, t);
    check("wrap_frames", start_q.size(), 80);

    // Random gaps, including writes that land during a stop bit
    start_q.delete();
    for (int i = 0; i < 20; i++) begin
      i_tx_valid = 1'b1;
      i_tx_data  = 8'($urandom_range(0, 255));
      exp_q.push_back(i_tx_data);
      @(posedge i_clk_20mhz); #1;
      i_tx_valid = 1'b0;
      repeat ($urandom_range(0, 300)) begin
        @(posedge i_clk_20mhz); #1;
      end
    end
    wait_idle(21 * FRAME, t);
    check("gap_frames", start_q.size(), 20);
    for (int i = 1; i < start_q.size(); i++)
      check("gap_spacing_min", (start_q[i] - start_q[i-1]) >= FRAME, 1'b1);

    // Reset in the middle of bit 4 of 0xA3, with 3 more bytes queued
    stim_q.delete();
    stim_q.push_back(8'hA3);
    for (int i = 0; i < 3; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    push_all(0, e0);
    wait_until(e0 + 1 + 5 * CLKS + CLKS / 2);
    check("mid_bit4_value", o_uart_tx, 1'b0);
    i_rstn_20mhz = 1'b0;
    @(posedge i_clk_20mhz); #1;
    check("mid_rst_line", o_uart_tx, 1'b1);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_ready", o_tx_ready, 1'b1);
    check("mid_rst_state", dbg_state, 2'd0);
    @(posedge i_clk_20mhz); #1;
    i_rstn_20mhz = 1'b1;
    start_q.delete();
    repeat (3 * FRAME) begin
      @(posedge i_clk_20mhz); #1;
    end
    check("mid_rst_no_frames", start_q.size(), 0);
    check("mid_rst_line_idle", o_uart_tx, 1'b1);
    check("mid_rst_busy_after", o_busy, 1'b0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
